// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared MDIO frame codes, field widths and FSM encoding
package mdio_pkg;

   localparam int PHYAD_W = 5;
   localparam int REGAD_W = 5;
   localparam int DATA_W  = 16;

   // Start-of-frame codes; the first ST bit is always 0, the second picks the clause
   localparam logic [1:0] ST_C22 = 2'b01;
   localparam logic [1:0] ST_C45 = 2'b00;

   localparam logic [1:0] OP22_WR    = 2'b01;
   localparam logic [1:0] OP22_RD    = 2'b10;
   localparam logic [1:0] OP45_ADDR  = 2'b00;
   localparam logic [1:0] OP45_WR    = 2'b01;
   localparam logic [1:0] OP45_RDINC = 2'b10;
   localparam logic [1:0] OP45_RD    = 2'b11;

   // Turnaround driven by the station on write/address frames
   localparam logic [1:0] TA_PAT = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA, S_SKIP
   } state_t;

   typedef enum logic [1:0] {
      K_WRITE, K_READ, K_ADDR, K_RDINC
   } kind_t;

   function automatic logic is_read(input kind_t k);
      return (k == K_READ) || (k == K_RDINC);
   endfunction

endpackage

// File: rtl/mdio_receptor_c45_if.sv
// rtl/mdio_receptor_c45_if.sv - serial line and register-file strobe bundle
interface mdio_receptor_c45_if;
   import mdio_pkg::*;

   logic                MDIO_OE;
   logic                MDIO_OUT;
   logic [DATA_W-1:0]   RD_DATA;
   logic                MDIO_IN;
   logic                MDIO_IN_OE;
   logic                RD_STB;
   logic                WR_STB;
   logic                MDIO_DONE;
   logic                IS_C45;
   logic [REGAD_W-1:0]  ADDR;
   logic [DATA_W-1:0]   C45_ADDR;
   logic [DATA_W-1:0]   WR_DATA;

   // Station manager and register file side
   modport master (
      output MDIO_OE, MDIO_OUT, RD_DATA,
      input  MDIO_IN, MDIO_IN_OE, RD_STB, WR_STB, MDIO_DONE, IS_C45, ADDR, C45_ADDR, WR_DATA
   );

   // PHY receptor side
   modport slave (
      input  MDIO_OE, MDIO_OUT, RD_DATA,
      output MDIO_IN, MDIO_IN_OE, RD_STB, WR_STB, MDIO_DONE, IS_C45, ADDR, C45_ADDR, WR_DATA
   );

endinterface

// File: rtl/mdio_preamble_det.sv
// rtl/mdio_preamble_det.sv - saturating preamble ones counter with start qualification
module mdio_preamble_det
   import mdio_pkg::*;
#(
   parameter int PREAMBLE_MIN = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic oe,
   input  logic bit_in,
   output logic start_ok
);

   localparam logic [5:0] MIN = 6'(PREAMBLE_MIN);

   logic [5:0] cnt;

   // Count driven 1s while idle; any other sample, or leaving idle, restarts the count
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt <= 6'd0;
      end else if (oe && bit_in) begin
         if (cnt != MIN) cnt <= cnt + 6'd1;
      end else begin
         cnt <= 6'd0;
      end
   end

   // Counter saturates at MIN, so equality is the same as reaching the minimum
   assign start_ok = (MIN == 6'd0) || (cnt == MIN);

endmodule

// File: rtl/mdio_receptor_c45.sv
// rtl/mdio_receptor_c45.sv - Clause-22/45 MDIO frame receiver, PHY side
module mdio_receptor_c45
   import mdio_pkg::*;
#(
   parameter logic [4:0]  PHY_ADDR     = 5'h01,
   parameter int          PREAMBLE_MIN = 32,
   parameter bit          C45_EN       = 1'b1,
   parameter logic [31:0] DEV_MASK     = 32'h0000_0002
) (
   input  logic                MDC,
   input  logic                rst,
   mdio_receptor_c45_if.slave  bus
);

   state_t      state, state_nx;
   logic [5:0]  e_cnt;          // number of the edge being sampled now (E2..E32)
   logic [14:0] rx_sh;          // previously sampled bits, newest in bit 0
   logic [15:0] tx_sh;
   logic        c45_r;
   kind_t       kind_r, kind_dec;
   logic        kind_ok;
   logic        start_ok;

   logic        bit_in, oe_in;
   logic [1:0]  op_now;
   logic [4:0]  fld5;
   logic [15:0] data_now;
   logic        last_edge, dev_ok, accept14;

   logic        rd_stb_nx, wr_stb_nx, done_nx, oe_nx, in_nx;
   logic        load_tx, shift_tx, addr_ld, wr_ld, c45_ld, c45_inc;

   assign bit_in    = bus.MDIO_OUT;
   assign oe_in     = bus.MDIO_OE;
   assign op_now    = {rx_sh[0], bit_in};
   assign fld5      = {rx_sh[3:0], bit_in};
   assign data_now  = {rx_sh[14:0], bit_in};
   assign last_edge = (e_cnt == 6'd32);
   assign dev_ok    = !c45_r || DEV_MASK[fld5];
   assign accept14  = (state == S_REGAD) && oe_in && (e_cnt == 6'd14) && dev_ok;

   mdio_preamble_det #(.PREAMBLE_MIN(PREAMBLE_MIN)) u_pre (
      .clk      (MDC),
      .rst      (rst),
      .en       (state == S_IDLE),
      .oe       (oe_in),
      .bit_in   (bit_in),
      .start_ok (start_ok)
   );

   // Opcode decode; Clause-22 only knows read and write
   always_comb begin
      kind_dec = K_WRITE;
      kind_ok  = 1'b0;
      if (c45_r) begin
         kind_ok = 1'b1;
         case (op_now)
            OP45_ADDR:  kind_dec = K_ADDR;
            OP45_WR:    kind_dec = K_WRITE;
            OP45_RDINC: kind_dec = K_RDINC;
            default:    kind_dec = K_READ;
         endcase
      end else begin
         case (op_now)
            OP22_WR: begin kind_dec = K_WRITE; kind_ok = 1'b1; end
            OP22_RD: begin kind_dec = K_READ;  kind_ok = 1'b1; end
            default: begin kind_dec = K_WRITE; kind_ok = 1'b0; end
         endcase
      end
   end

   // State register and frame edge counter
   always_ff @(posedge MDC) begin
      if (rst) begin
         state <= S_IDLE;
         e_cnt <= 6'd0;
      end else begin
         state <= state_nx;
         e_cnt <= (state == S_IDLE) ? 6'd2 : e_cnt + 6'd1;
      end
   end

   // Next-state: field boundaries are located by the edge counter
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (oe_in && !bit_in && start_ok) state_nx = S_ST2;
         S_ST2: begin
            if (!oe_in)                  state_nx = S_IDLE;
            else if (bit_in == ST_C22[0]) state_nx = S_OP;
            else if (C45_EN)             state_nx = S_OP;
            else                         state_nx = S_SKIP;
         end
         S_OP: begin
            if (!oe_in)                  state_nx = S_IDLE;
            else if (e_cnt == 6'd4)      state_nx = kind_ok ? S_PHYAD : S_SKIP;
         end
         S_PHYAD: begin
            if (!oe_in)                  state_nx = S_IDLE;
            else if (e_cnt == 6'd9)      state_nx = (fld5 == PHY_ADDR) ? S_REGAD : S_SKIP;
         end
         S_REGAD: begin
            if (!oe_in)                  state_nx = S_IDLE;
            else if (e_cnt == 6'd14) begin
               if (!dev_ok)              state_nx = S_SKIP;
               else if (is_read(kind_r)) state_nx = S_RDATA;
               else                      state_nx = S_TA;
            end
         end
         S_TA: begin
            if (!oe_in)                  state_nx = S_IDLE;
            else if (e_cnt == 6'd15) begin
               if (bit_in != TA_PAT[1])  state_nx = S_SKIP;
            end else if (bit_in != TA_PAT[0]) state_nx = S_SKIP;
            else                         state_nx = S_WDATA;
         end
         S_WDATA: begin
            if (!oe_in)                  state_nx = S_IDLE;
            else if (last_edge)          state_nx = S_IDLE;
         end
         S_RDATA, S_SKIP: if (last_edge) state_nx = S_IDLE;
         default:                        state_nx = S_IDLE;
      endcase
   end

   // Output decode: strobes, line drive and datapath load enables for this edge
   always_comb begin
      rd_stb_nx = 1'b0;
      wr_stb_nx = 1'b0;
      done_nx   = 1'b0;
      oe_nx     = 1'b0;
      in_nx     = 1'b0;
      load_tx   = 1'b0;
      shift_tx  = 1'b0;
      addr_ld   = 1'b0;
      wr_ld     = 1'b0;
      c45_ld    = 1'b0;
      c45_inc   = 1'b0;
      if (accept14) begin
         addr_ld   = 1'b1;
         rd_stb_nx = is_read(kind_r);
      end
      if (state == S_RDATA) begin
         if (last_edge) begin
            done_nx = 1'b1;
            c45_inc = (kind_r == K_RDINC);
         end else if (e_cnt == 6'd15) begin
            oe_nx   = 1'b1;
            load_tx = 1'b1;
         end else begin
            oe_nx    = 1'b1;
            in_nx    = tx_sh[15];
            shift_tx = 1'b1;
         end
      end
      if ((state == S_WDATA) && oe_in && last_edge) begin
         done_nx = 1'b1;
         if (kind_r == K_ADDR) begin
            c45_ld = 1'b1;
         end else begin
            wr_ld     = 1'b1;
            wr_stb_nx = 1'b1;
         end
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge MDC) begin
      if (rst) begin
         rx_sh          <= '0;
         tx_sh          <= '0;
         c45_r          <= 1'b0;
         kind_r         <= K_WRITE;
         bus.RD_STB     <= 1'b0;
         bus.WR_STB     <= 1'b0;
         bus.MDIO_DONE  <= 1'b0;
         bus.MDIO_IN_OE <= 1'b0;
         bus.MDIO_IN    <= 1'b0;
         bus.ADDR       <= '0;
         bus.IS_C45     <= 1'b0;
         bus.WR_DATA    <= '0;
         bus.C45_ADDR   <= '0;
      end else begin
         rx_sh          <= data_now[14:0];
         bus.RD_STB     <= rd_stb_nx;
         bus.WR_STB     <= wr_stb_nx;
         bus.MDIO_DONE  <= done_nx;
         bus.MDIO_IN_OE <= oe_nx;
         bus.MDIO_IN    <= in_nx;
         if (state == S_ST2)                    c45_r  <= (bit_in == ST_C45[0]);
         if ((state == S_OP) && (e_cnt == 6'd4)) kind_r <= kind_dec;
         if (load_tx)       tx_sh <= bus.RD_DATA;
         else if (shift_tx) tx_sh <= {tx_sh[14:0], 1'b0};
         if (addr_ld) begin
            bus.ADDR   <= fld5;
            bus.IS_C45 <= c45_r;
         end
         if (wr_ld)        bus.WR_DATA  <= data_now;
         if (c45_ld)       bus.C45_ADDR <= data_now;
         else if (c45_inc) bus.C45_ADDR <= bus.C45_ADDR + 16'd1;
      end
   end

endmodule

// File: tb/tb_mdio_receptor_c45.sv
// tb/tb_mdio_receptor_c45.sv - scoreboard bench for the Clause-22/45 MDIO receptor
module tb_mdio_receptor_c45;
   import mdio_pkg::*;

   logic MDC = 1'b0;
   logic rst = 1'b1;
   always #5 MDC = ~MDC;

   mdio_receptor_c45_if bus ();
   mdio_receptor_c45_if bus0 ();

   mdio_receptor_c45 #(.PHY_ADDR(5'h01), .PREAMBLE_MIN(32), .C45_EN(1'b1), .DEV_MASK(32'h0000_0002)) dut (
      .MDC(MDC), .rst(rst), .bus(bus));

   mdio_receptor_c45 #(.PHY_ADDR(5'h07), .PREAMBLE_MIN(0), .C45_EN(1'b1), .DEV_MASK(32'h0000_0002)) dut0 (
      .MDC(MDC), .rst(rst), .bus(bus0));

   assign bus0.MDIO_OE  = bus.MDIO_OE;
   assign bus0.MDIO_OUT = bus.MDIO_OUT;
   assign bus0.RD_DATA  = 16'h0000;

   typedef struct {
      bit          wr;
      bit          rd;
      logic [4:0]  addr;
      bit          c45;
      logic [15:0] data;
      logic [15:0] c45a;
   } exp_t;

   exp_t exp_q[$];
   exp_t q0[$];
   exp_t em, e0;
   int   n_pass = 0;
   int   n_total = 0;
   logic [15:0] rd_value = 16'h0000;
   int   rd_cnt = 0;
   int   oe_cnt = 0;
   logic [16:0] ser = '0;
   bit   prev_rd = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", nm, act, exp);
   endtask

   function automatic exp_t mk(input bit wr, input bit rd, input logic [4:0] a, input bit c45,
                               input logic [15:0] d, input logic [15:0] ca);
      exp_t e;
      e.wr = wr; e.rd = rd; e.addr = a; e.c45 = c45; e.data = d; e.c45a = ca;
      return e;
   endfunction

   task automatic drive_bit(input bit oe, input bit b);
      @(negedge MDC);
      bus.MDIO_OE  = oe;
      bus.MDIO_OUT = b;
   endtask

   task automatic idle(input int n);
      repeat (n) drive_bit(1'b0, 1'b1);
   endtask

   task automatic send(input int pre, input logic [1:0] st, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] rg, input logic [1:0] ta, input logic [15:0] d,
                       input bit rd, input int nd);
      logic [13:0] hdr;
      hdr = {st, op, phy, rg};
      repeat (pre) drive_bit(1'b1, 1'b1);
      for (int i = 13; i >= 0; i--) drive_bit(1'b1, hdr[i]);
      if (rd) begin
         repeat (18) drive_bit(1'b0, 1'b1);
      end else begin
         drive_bit(1'b1, ta[1]);
         drive_bit(1'b1, ta[0]);
         for (int i = 15; i >= 16 - nd; i--) drive_bit(1'b1, d[i]);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_in_oe"},   bus.MDIO_IN_OE, 0);
      chk({tag, "_in"},      bus.MDIO_IN, 0);
      chk({tag, "_strobes"}, {bus.RD_STB, bus.WR_STB, bus.MDIO_DONE}, 0);
      chk({tag, "_addr"},    bus.ADDR, 0);
      chk({tag, "_is_c45"},  bus.IS_C45, 0);
      chk({tag, "_c45_addr"}, bus.C45_ADDR, 0);
      chk({tag, "_wr_data"}, bus.WR_DATA, 0);
   endtask

   // Register file model: data is only valid in the RD_STB cycle
   always @(negedge MDC) bus.RD_DATA = bus.RD_STB ? rd_value : 16'hDEAD;

   // Main monitor: accumulates read-side activity and scores each DONE
   always @(negedge MDC) begin
      if (rst) begin
         rd_cnt = 0; oe_cnt = 0; ser = '0; prev_rd = 1'b0;
      end else begin
         if (prev_rd) chk("rd_stb_then_oe", bus.MDIO_IN_OE, 1);
         prev_rd = bus.RD_STB;
         if (bus.RD_STB) begin
            rd_cnt++;
            chk("rd_stb_exclusive", {bus.WR_STB, bus.MDIO_DONE}, 0);
         end
         if (bus.MDIO_IN_OE) begin
            oe_cnt++;
            ser = {ser[15:0], bus.MDIO_IN};
         end
         if (bus.MDIO_DONE) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               em = exp_q.pop_front();
               chk("wr_stb", bus.WR_STB, em.wr);
               chk("rd_stb_count", rd_cnt, em.rd ? 1 : 0);
               chk("in_oe_cycles", oe_cnt, em.rd ? 17 : 0);
               if (em.rd) chk("read_serial", ser, {1'b0, em.data});
               else       chk("wr_data", bus.WR_DATA, em.data);
               chk("addr", bus.ADDR, em.addr);
               chk("is_c45", bus.IS_C45, em.c45);
               chk("c45_addr", bus.C45_ADDR, em.c45a);
            end
            rd_cnt = 0; oe_cnt = 0; ser = '0;
         end else if (bus.WR_STB) begin
            chk("wr_stb_without_done", 1, 0);
         end
      end
   end

   // Second instance: no-preamble configuration answering PHYAD 07
   always @(negedge MDC) begin
      if (!rst && bus0.MDIO_DONE) begin
         if (q0.size() == 0) begin
            chk("dut0_unexpected_done", 1, 0);
         end else begin
            e0 = q0.pop_front();
            chk("dut0_wr_stb", bus0.WR_STB, e0.wr);
            chk("dut0_wr_data", bus0.WR_DATA, e0.data);
            chk("dut0_addr", bus0.ADDR, e0.addr);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [13:0] hdr;
      bus.MDIO_OE  = 1'b0;
      bus.MDIO_OUT = 1'b1;
      bus.RD_DATA  = 16'hDEAD;
      rst = 1'b1;
      idle(3);
      chk_zero("reset");
      rst = 1'b0;
      idle(2);

      // Clause-22 write
      exp_q.push_back(mk(1, 0, 5'h05, 0, 16'hA5C3, 16'h0000));
      send(32, ST_C22, OP22_WR, 5'h01, 5'h05, TA_PAT, 16'hA5C3, 0, 16);
      idle(4);

      // Clause-22 read
      rd_value = 16'h1234;
      exp_q.push_back(mk(0, 1, 5'h02, 0, 16'h1234, 16'h0000));
      send(32, ST_C22, OP22_RD, 5'h01, 5'h02, TA_PAT, 16'h0000, 1, 16);
      idle(4);

      // Foreign PHY address, then a valid frame
      send(32, ST_C22, OP22_WR, 5'h03, 5'h05, TA_PAT, 16'hFFFF, 0, 16);
      idle(4);
      exp_q.push_back(mk(1, 0, 5'h1F, 0, 16'h0F0F, 16'h0000));
      send(32, ST_C22, OP22_WR, 5'h01, 5'h1F, TA_PAT, 16'h0F0F, 0, 16);
      idle(4);

      // Clause-45 address FFFF, two read-increments wrapping through 0000
      exp_q.push_back(mk(0, 0, 5'h01, 1, 16'h0F0F, 16'hFFFF));
      send(32, ST_C45, OP45_ADDR, 5'h01, 5'h01, TA_PAT, 16'hFFFF, 0, 16);
      idle(4);
      rd_value = 16'h0BEE;
      exp_q.push_back(mk(0, 1, 5'h01, 1, 16'h0BEE, 16'h0000));
      send(32, ST_C45, OP45_RDINC, 5'h01, 5'h01, TA_PAT, 16'h0000, 1, 16);
      idle(4);
      exp_q.push_back(mk(0, 1, 5'h01, 1, 16'h0BEE, 16'h0001));
      send(32, ST_C45, OP45_RDINC, 5'h01, 5'h01, TA_PAT, 16'h0000, 1, 16);
      idle(4);

      // Clause-45 write leaves the address register alone
      exp_q.push_back(mk(1, 0, 5'h01, 1, 16'h1357, 16'h0001));
      send(32, ST_C45, OP45_WR, 5'h01, 5'h01, TA_PAT, 16'h1357, 0, 16);
      idle(4);

      // Rejected frames: unsupported DEVAD, bad C22 opcode, bad TA, truncated write
      send(32, ST_C45, OP45_RD, 5'h01, 5'h02, TA_PAT, 16'h0000, 1, 16);
      idle(4);
      send(32, ST_C22, 2'b00, 5'h01, 5'h04, TA_PAT, 16'h1111, 0, 16);
      idle(4);
      send(32, ST_C22, OP22_WR, 5'h01, 5'h06, 2'b11, 16'h2222, 0, 16);
      idle(4);
      send(32, ST_C22, OP22_WR, 5'h01, 5'h06, TA_PAT, 16'h3333, 0, 4);
      idle(2);

      // 31-bit preamble is too short; a full preamble right after is accepted
      send(31, ST_C22, OP22_WR, 5'h01, 5'h08, TA_PAT, 16'h4444, 0, 16);
      exp_q.push_back(mk(1, 0, 5'h07, 0, 16'h8001, 16'h0001));
      send(32, ST_C22, OP22_WR, 5'h01, 5'h07, TA_PAT, 16'h8001, 0, 16);
      idle(4);

      // Preamble suppression, back-to-back frames on the second instance
      q0.push_back(mk(1, 0, 5'h09, 0, 16'h5A5A, 16'h0000));
      send(0, ST_C22, OP22_WR, 5'h07, 5'h09, TA_PAT, 16'h5A5A, 0, 16);
      q0.push_back(mk(1, 0, 5'h0A, 0, 16'h00FF, 16'h0000));
      send(0, ST_C22, OP22_WR, 5'h07, 5'h0A, TA_PAT, 16'h00FF, 0, 16);
      idle(4);

      // Reset sampled at E20 of a read-increment
      rd_value = 16'hBEEF;
      hdr = {ST_C45, OP45_RDINC, 5'h01, 5'h01};
      repeat (32) drive_bit(1'b1, 1'b1);
      for (int i = 13; i >= 0; i--) drive_bit(1'b1, hdr[i]);
      repeat (5) drive_bit(1'b0, 1'b1);
      drive_bit(1'b0, 1'b1);
      rst = 1'b1;
      @(negedge MDC);
      chk_zero("midframe_reset");
      rst = 1'b0;
      idle(30);

      // Normal operation resumes after the reset
      exp_q.push_back(mk(1, 0, 5'h05, 0, 16'hCAFE, 16'h0000));
      send(32, ST_C22, OP22_WR, 5'h01, 5'h05, TA_PAT, 16'hCAFE, 0, 16);
      idle(6);

      chk("main_queue_drained", exp_q.size(), 0);
      chk("dut0_queue_drained", q0.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mdio_receptor_c45.md
Name: mdio_receptor_c45

Overview:
- Parametrised MDIO management-frame receiver on the PHY side, successor to the fixed Clause-22 receptor.
- Decodes both Clause-22 and Clause-45 frames: address, write, read and post-read-increment.
- Filters frames by PHY/port address and a supported-device mask, and keeps a per-block 16-bit Clause-45 address register.
- Sits between the station-management serial line (MDC/MDIO) and the register file, which it accesses through strobe/data ports.

Parameters:
- PHY_ADDR, 5'h01, PHYAD/PRTAD this block answers to.
- PREAMBLE_MIN, 32, consecutive 1s required before ST. Legal range 0..32; 0 = preamble suppression, where ST is accepted directly from IDLE.
- C45_EN, 1, 1 = accept ST=00 frames; 0 = treat them as not-for-us.
- DEV_MASK, 32'h0000_0002, bit n set = Clause-45 DEVAD n is supported.

Ports:
- MDC  in  1  clock. All sampling and driving happens on the rising edge.
- rst  in  1  synchronous, active-high reset.
- MDIO_OE  in  1  station manager is driving the line.
- MDIO_OUT  in  1  serial bit from the station manager.
- RD_DATA  in  16  register read data. Must be valid in the cycle RD_STB is high.
- MDIO_IN  out  1  serial read data returned to the station manager.
- MDIO_IN_OE  out  1  this block drives MDIO_IN.
- RD_STB  out  1  one-cycle read request.
- WR_STB  out  1  one-cycle write strobe.
- MDIO_DONE  out  1  one-cycle end-of-frame pulse. Fires for accepted frames only.
- IS_C45  out  1  the current/last accepted frame is Clause-45.
- ADDR  out  5  REGAD (C22) or DEVAD (C45).
- C45_ADDR  out  16  Clause-45 address register.
- WR_DATA  out  16  write data. Held until the next write.

Behaviour:
- Reset:
  - All outputs are 0. C45_ADDR=0. FSM=IDLE. Preamble counter=0.
  - Reset mid-frame: MDIO_IN_OE=0 at the next edge and the frame is dropped.
- Bit numbering: edges after the preamble are E1 and E2 (ST), E3-E4 (OP), E5-E9 (PHYAD), E10-E14 (REGAD/DEVAD), E15-E16 (TA), E17-E32 (data).
- IDLE/PRE:
  - Each sampled 1 with MDIO_OE=1 increments a counter that saturates at PREAMBLE_MIN.
  - A sampled 0 with counter>=PREAMBLE_MIN is taken as ST bit 1 and the FSM moves to ST2. Any other 0 clears the counter.
- ST2:
  - 1 -> C22.
  - 0 -> C45 if C45_EN, otherwise SKIP.
- OP:
  - C22: 01=write, 10=read. Other codes -> SKIP.
  - C45: 00=address, 01=write, 11=read, 10=read-increment.
- At E9:
  - PHYAD != PHY_ADDR -> SKIP.
  - At E14, C45 with DEV_MASK[DEVAD]=0 -> SKIP.
  - SKIP counts to E32 and returns to IDLE with no strobes, no DONE and no drive.
- Read path (C22 read, C45 read, C45 read-increment):
  - RD_STB=1 for the cycle after E14.
  - RD_DATA is captured at E15 into a shift register.
  - After E15: MDIO_IN_OE=1, MDIO_IN=0 (second TA bit).
  - After E16..E31: MDIO_IN carries D15..D0, MSB first.
  - After E32: MDIO_IN_OE=0 and MDIO_DONE=1 for one cycle.
  - Read-increment: C45_ADDR increments by 1 in the same cycle as DONE, wrapping FFFF->0000.
- Write/address paths:
  - The TA bits sampled at E15/E16 must be 1,0; otherwise -> SKIP (abort).
  - Data is shifted in at E17..E32, MSB first.
  - After E32, C22 write or C45 write: WR_DATA updated, WR_STB=1 and MDIO_DONE=1 for one cycle.
  - After E32, C45 address frame: C45_ADDR=data and MDIO_DONE=1. No WR_STB.
  - C45 write does not increment C45_ADDR.
- MDIO_OE=0 sampled during a write/address frame, E1-E32 excluding read TA/data: abort to IDLE and clear the counter.
- ADDR and IS_C45 update at E14 and hold until the next accepted frame.
- Back-to-back frames: the FSM is in IDLE after E32. With PREAMBLE_MIN=0, a 0 sampled at E33 starts the next frame.
- RD_STB, WR_STB and MDIO_DONE are never high together except WR_STB with DONE.

Decomposition:
- Shared package mdio_pkg holds:
  - ST codes (C22=2'b01, C45=2'b00).
  - OP codes for both clauses.
  - FSM state encoding: IDLE, ST2, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP.
  - Field widths: 5/5/16.
  - TA pattern.
- One sub-module, mdio_preamble_det: saturating 1s counter with the PREAMBLE_MIN compare, producing start_ok.

Test Plan:
- C22 write, PHYAD=01, REGAD=05, data=A5C3, 32-bit preamble -> after E32, WR_STB=1 and DONE=1 for 1 cycle, ADDR=05, WR_DATA=A5C3, IS_C45=0.
- C22 read, REGAD=02, RD_DATA=1234 -> RD_STB 1 cycle after E14; MDIO_IN_OE high E15..E32; MDIO_IN shows 0 then 0001001000110100; DONE after E32.
- C22 write to PHYAD=03 -> no RD_STB/WR_STB/DONE, MDIO_IN_OE stays 0; the following valid frame is accepted.
- C45 address DEVAD=1, data=FFFF, then two read-increments with RD_DATA=0BEE -> C45_ADDR goes FFFF -> 0000 -> 0001; both reads return 0BEE.
- Preamble of 31 ones then a valid frame (PREAMBLE_MIN=32) -> ignored. Repeat with PREAMBLE_MIN=0 and no preamble -> accepted.
- rst asserted at E20 of a read -> MDIO_IN_OE=0 next edge, no DONE, all outputs 0, C45_ADDR=0.
